mantissa_mul_unit: RTL
======================

MANTISSA_MUL_UNIT -- requirements
Module: mantissa_mul_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 24, operand width in bits (1.23 significand incl. hidden bit).
REQ-002 SHALL have parameter EARLY_ZERO, default 1, enables the zero-operand early-out path.
REQ-003 CLK  input  1  clock; all state updates on rising edge.
REQ-004 RSTn  input  1  reset: synchronous, active-low.
REQ-005 Multi_datain1  input  WIDTH  multiplicand significand.
REQ-006 Multi_datain2  input  WIDTH  multiplier significand.
REQ-007 Multi_valid  input  1  request from the caller; held high until Multi_ack has been seen.
REQ-008 Multi_dataout  output  2*WIDTH  unsigned product; valid while Multi_ack=1.
REQ-009 Multi_Exc  output  3  exception code; valid while Multi_ack=1; 3'b000 = none, 3'b001 = zero product.
REQ-010 Multi_ack  output  1  result-ready acknowledge.
REQ-011 Busy  output  1  high in BUSY state; debug only.

Function
REQ-012 SHALL implement a four-phase handshake responder: valid rises -> (compute) -> ack rises -> valid falls -> ack falls.
REQ-013 FSM states SHALL be IDLE, BUSY, DONE.
REQ-014 IDLE transitions:
- Multi_valid=1 and not early-out: latch both operands, clear the 2*WIDTH accumulator, load counter=0, go to BUSY.
- Multi_valid=1 and early-out (EARLY_ZERO=1, either operand == 0): load product 0 and Exc 3'b001, go to DONE.
REQ-015 Each BUSY cycle SHALL perform one radix-2 shift-add step:
- If multiplier LSB is 1, add the multiplicand into the accumulator upper half with carry.
- Shift the accumulator right by 1.
- Increment the counter.
REQ-016 After exactly WIDTH BUSY cycles, SHALL go to DONE with the exact unsigned product; no rounding or truncation.
REQ-017 Latency: with valid sampled at edge 0, Multi_ack SHALL be high from edge WIDTH+1 (edge 25 at default); early-out ack from edge 1.
REQ-018 DONE: Multi_ack=1; Multi_dataout and Multi_Exc held stable; stays in DONE while Multi_valid=1.
REQ-019 DONE with Multi_valid=0 SHALL return to IDLE; ack drops on the same edge.
REQ-020 A new request SHALL NOT be accepted in the cycle ack drops; earliest acceptance is the following IDLE cycle.
REQ-021 Multi_valid falling during BUSY SHALL abort: return to IDLE, no ack generated, accumulator discarded.
REQ-022 Operand changes during BUSY or DONE SHALL be ignored; operands are latched only in IDLE.
REQ-023 With EARLY_ZERO=0, zero operands SHALL take the full WIDTH cycles; Exc is 3'b001 if the product is 0.
REQ-024 Multi_Exc SHALL be 3'b000 for any nonzero product; Multi_dataout and Multi_Exc are 0 whenever ack=0.
REQ-025 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-026 RSTn=0 at a rising edge SHALL force IDLE and set Multi_ack=0, Multi_dataout=0, Multi_Exc=0, Busy=0, counter=0, accumulator=0.
REQ-027 Reset SHALL take priority over every other event, including mid-BUSY and in DONE; the pending operation is lost.

Structure
REQ-028 The state enum (IDLE/BUSY/DONE) and the exception codes SHALL live in a shared FPU package:
- EXC_NONE=3'b000, EXC_ZERO=3'b001, EXC_OVF=3'b010, EXC_INEXACT=3'b101.
- The same package is used by the multiply controller.
REQ-029 One sub-module is natural: mul_shift_add_step, a combinational single-step datapath (accumulator, multiplicand, multiplier bit -> next accumulator); the FSM and counter stay in the top.

Verification
REQ-030 24'h800000 x 24'h800000 -> Multi_dataout=48'h400000000000, Exc=0, ack at edge 25, held until valid drops.
REQ-031 24'hFFFFFF x 24'hFFFFFF -> 48'hFFFFFE000001, Exc=0; 24'hC00000 x 24'hA00000 -> 48'h780000000000.
REQ-032 Zero operand with EARLY_ZERO=1:
- 24'h000000 x 24'h9ABCDE -> dataout 0, Exc=3'b001, ack at edge 1.
- Repeat with EARLY_ZERO=0 -> same result, ack at edge 25.
REQ-033 Abort: drop valid at edge 10 -> no ack ever; next request 24'h800001 x 24'h800000 -> 48'h400000800000.
REQ-034 Reset: RSTn low at edge 12 of BUSY -> all outputs 0 next edge, IDLE; a subsequent operation completes correctly.
REQ-035 Back-to-back: valid re-asserted the cycle after ack falls -> accepted, second product correct, ack never glitches.

Source files
------------

// File: rtl/mantissa_mul_unit_pkg.sv
// Shared FPU definitions used by the significand multiplier and the multiply
// controller: the handshake FSM state encoding and the exception codes that
// travel alongside a product.
//
// Contents:
//   mul_state_t  IDLE / BUSY / DONE
//   exc_t        3-bit exception code
//   EXC_*        exception code values
package mantissa_mul_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  typedef logic [2:0] exc_t;

  localparam exc_t EXC_NONE    = 3'b000;
  localparam exc_t EXC_ZERO    = 3'b001;
  localparam exc_t EXC_OVF     = 3'b010;
  localparam exc_t EXC_INEXACT = 3'b101;

endpackage

// File: rtl/mantissa_mul_unit_if.sv
// Request/response bundle between a caller and the significand multiplier.
//
// Signals:
//   Multi_datain1  multiplicand significand       (caller -> multiplier)
//   Multi_datain2  multiplier significand         (caller -> multiplier)
//   Multi_valid    request, held until ack seen   (caller -> multiplier)
//   Multi_dataout  2*WIDTH unsigned product       (multiplier -> caller)
//   Multi_Exc      exception code                 (multiplier -> caller)
//   Multi_ack      result-ready acknowledge       (multiplier -> caller)
// Modports: master = caller side, slave = multiplier side.
interface mantissa_mul_unit_if
  import mantissa_mul_unit_pkg::*;
#(
  parameter int WIDTH = 24
) ();

  logic [WIDTH-1:0]   Multi_datain1;
  logic [WIDTH-1:0]   Multi_datain2;
  logic               Multi_valid;
  logic [2*WIDTH-1:0] Multi_dataout;
  exc_t               Multi_Exc;
  logic               Multi_ack;

  modport master (
    output Multi_datain1,
    output Multi_datain2,
    output Multi_valid,
    input  Multi_dataout,
    input  Multi_Exc,
    input  Multi_ack
  );

  modport slave (
    input  Multi_datain1,
    input  Multi_datain2,
    input  Multi_valid,
    output Multi_dataout,
    output Multi_Exc,
    output Multi_ack
  );

endinterface

// File: rtl/mantissa_mul_unit_mul_shift_add_step.sv
// One radix-2 shift-add multiply step, purely combinational.
// Adds the multiplicand into the upper half of the accumulator when the
// current multiplier bit is set (keeping the carry), then shifts right by one.
//
// Ports:
//   acc       accumulator bits [2*WIDTH-1:1]; bit 0 is shifted out by this
//             step, so it is never needed here
//   mcand     multiplicand
//   mbit      current multiplier LSB
//   acc_next  accumulator after the step
module mul_shift_add_step #(
  parameter int WIDTH = 24
) (
  input  logic [2*WIDTH-1:1] acc,
  input  logic [WIDTH-1:0]   mcand,
  input  logic               mbit,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   upper_sum;

  assign addend    = mbit ? mcand : '0;
  assign upper_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};

  // The carry out of the add becomes the new MSB after the right shift.
  assign acc_next  = {upper_sum, acc[WIDTH-1:1]};

endmodule

// File: rtl/mantissa_mul_unit.sv
// Sequential significand multiplier with a four-phase handshake.
// A request is latched in IDLE, multiplied one bit per cycle in BUSY
// (WIDTH cycles), and the exact 2*WIDTH-bit product is presented in DONE
// with Multi_ack until the caller drops Multi_valid. With EARLY_ZERO set, a
// zero operand skips BUSY and reports EXC_ZERO straight away.
//
// Ports:
//   CLK   clock, rising edge
//   RSTn  synchronous active-low reset
//   bus   request/response bundle (slave side)
//   Busy  high while in BUSY (debug)
module mantissa_mul_unit
  import mantissa_mul_unit_pkg::*;
#(
  parameter int WIDTH      = 24,
  parameter bit EARLY_ZERO = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  mantissa_mul_unit_if.slave   bus,
  output logic                 Busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  mul_state_t       state, state_next;
  logic [PW-1:0]    acc, acc_next, step_acc;
  logic [WIDTH-1:0] mcand, mcand_next;
  logic [WIDTH-1:0] mplier, mplier_next;
  logic [CW-1:0]    count, count_next;
  logic             early_out;

  logic             ack_q, ack_next;
  logic             busy_q, busy_next;
  logic [PW-1:0]    dataout_q, dataout_next;
  exc_t             exc_q, exc_next;

  mul_shift_add_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc[PW-1:1]),
    .mcand    (mcand),
    .mbit     (mplier[0]),
    .acc_next (step_acc)
  );

  assign early_out = EARLY_ZERO &&
                     ((bus.Multi_datain1 == '0) || (bus.Multi_datain2 == '0));

  // State, datapath and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      count     <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      dataout_q <= '0;
      exc_q     <= EXC_NONE;
    end else begin
      state     <= state_next;
      acc       <= acc_next;
      mcand     <= mcand_next;
      mplier    <= mplier_next;
      count     <= count_next;
      ack_q     <= ack_next;
      busy_q    <= busy_next;
      dataout_q <= dataout_next;
      exc_q     <= exc_next;
    end
  end

  // Next-state and datapath update. In DONE the accumulator holds the product
  // (early-out loads it with zero), so it doubles as the result register.
  always_comb begin
    state_next  = state;
    acc_next    = acc;
    mcand_next  = mcand;
    mplier_next = mplier;
    count_next  = count;
    case (state)
      IDLE: begin
        if (bus.Multi_valid) begin
          acc_next   = '0;
          count_next = '0;
          if (early_out) begin
            state_next = DONE;
          end else begin
            mcand_next  = bus.Multi_datain1;
            mplier_next = bus.Multi_datain2;
            state_next  = BUSY;
          end
        end
      end
      BUSY: begin
        if (!bus.Multi_valid) begin
          acc_next   = '0;
          count_next = '0;
          state_next = IDLE;
        end else begin
          acc_next    = step_acc;
          mplier_next = mplier >> 1;
          count_next  = count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (!bus.Multi_valid) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode feeding the output registers. Ack follows the DONE state by
  // one edge and drops on the same edge the FSM leaves DONE.
  always_comb begin
    ack_next     = (state == DONE) && bus.Multi_valid;
    busy_next    = (state_next == BUSY);
    dataout_next = '0;
    exc_next     = EXC_NONE;
    if (ack_next) begin
      dataout_next = acc;
      exc_next     = (acc == '0) ? EXC_ZERO : EXC_NONE;
    end
  end

  assign bus.Multi_ack     = ack_q;
  assign bus.Multi_dataout = dataout_q;
  assign bus.Multi_Exc     = exc_q;
  assign Busy              = busy_q;

endmodule
